// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO between an upstream and a downstream
// valid/ready stream, with first-word fall-through on the output.
//
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst        - synchronous reset, active-low
//   up_data    - upstream data word
//   up_valid   - upstream offers up_data this cycle
//   up_ready   - FIFO can accept a word this cycle
//   down_data  - oldest stored word (head of queue)
//   down_valid - down_data holds a valid stored word
//   down_ready - downstream accepts down_data this cycle
//
// Parameters:
//   D_WIDTH - data word width in bits
//   DEPTH   - number of entries, power of two and >= 2
module stream_fifo #(
  parameter int unsigned D_WIDTH = 6,
  parameter int unsigned DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  input  logic               down_ready
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra MSB so that full and empty are distinguishable
  // when the low (index) bits coincide.
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic [D_WIDTH-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // Status is gated by rst so both handshakes are closed while in reset.
  // up_ready looks only at full, so a pop in the same cycle cannot free a
  // slot for a push until the following cycle.
  assign up_ready   = !w_full && rst;
  assign down_valid = !w_empty && rst;

  assign w_push = up_valid && up_ready;
  assign w_pop  = down_valid && down_ready;

  assign down_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_mem    <= '{default: '0};
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= up_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: self-checking bench for stream_fifo using a queue
// reference model updated from the handshake rules at each rising edge.
module tb_stream_fifo;

  localparam int D_WIDTH = 6;
  localparam int DEPTH   = 4;

  logic               clk;
  logic               rst;
  logic [D_WIDTH-1:0] up_data;
  logic               up_valid;
  logic               up_ready;
  logic [D_WIDTH-1:0] down_data;
  logic               down_valid;
  logic               down_ready;

  int n_cmp;
  int n_err;
  int n_push;

  logic [D_WIDTH-1:0] q[$];

  stream_fifo #(
    .D_WIDTH(D_WIDTH),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up_data   (up_data),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .down_data (down_data),
    .down_valid(down_valid),
    .down_ready(down_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock with the currently driven inputs and update the model.
  task automatic tick();
    bit                 push;
    bit                 pop;
    logic [D_WIDTH-1:0] d;
    push = rst && up_valid && (q.size() < DEPTH);
    pop  = rst && down_ready && (q.size() > 0);
    d    = up_data;
    @(posedge clk);
    if (!rst) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(d);
        n_push++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; up_valid = 1'b0; down_ready = 1'b0; up_data = '0;
    n_cmp++;
    if (up_ready !== 1'b0) begin n_err++; $display("FAIL rst_up_ready got=%b exp=0", up_ready); end
    n_cmp++;
    if (down_valid !== 1'b0) begin n_err++; $display("FAIL rst_down_valid got=%b exp=0", down_valid); end
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (up_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_up_ready got=%b exp=1", up_ready); end
    n_cmp++;
    if (down_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_down_valid got=%b exp=0", down_valid); end
    n_cmp++;
    if (down_data !== 6'h00) begin n_err++; $display("FAIL post_rst_down_data got=%h exp=00", down_data); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (up_ready !== 1'b1 || down_valid !== 1'b0) begin
        n_err++;
        $display("FAIL idle_status cyc=%0d got rdy=%b vld=%b exp rdy=1 vld=0", i, up_ready, down_valid);
      end
    end
  endtask

  task automatic test_single();
    up_data = 6'h2A; up_valid = 1'b1; down_ready = 1'b0;
    tick();
    up_valid = 1'b0; up_data = 6'h3F;
    n_cmp++;
    if (down_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got=%b exp=1", down_valid); end
    n_cmp++;
    if (down_data !== 6'h2A) begin n_err++; $display("FAIL single_data got=%h exp=2a", down_data); end
    down_ready = 1'b1;
    tick();
    down_ready = 1'b0;
    n_cmp++;
    if (down_valid !== 1'b0) begin n_err++; $display("FAIL single_pop_valid got=%b exp=0", down_valid); end
  endtask

  task automatic test_fill();
    logic [D_WIDTH-1:0] exp;
    down_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      up_data = 6'(k); up_valid = 1'b1;
      tick();
    end
    n_cmp++;
    if (up_ready !== 1'b0) begin n_err++; $display("FAIL fill_full got=%b exp=0", up_ready); end
    up_data = 6'h05;
    tick();
    up_valid = 1'b0;
    n_cmp++;
    if (up_ready !== 1'b0 || down_data !== 6'h01) begin
      n_err++;
      $display("FAIL fill_reject got rdy=%b head=%h exp rdy=0 head=01", up_ready, down_data);
    end
    down_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      exp = 6'(k);
      n_cmp++;
      if (down_valid !== 1'b1 || down_data !== exp) begin
        n_err++;
        $display("FAIL fill_drain k=%0d got vld=%b data=%h exp vld=1 data=%h", k, down_valid, down_data, exp);
      end
      tick();
    end
    down_ready = 1'b0;
    n_cmp++;
    if (down_valid !== 1'b0) begin n_err++; $display("FAIL fill_empty got=%b exp=0", down_valid); end
  endtask

  task automatic test_back_to_back();
    logic [D_WIDTH-1:0] exp;
    up_valid = 1'b1; down_ready = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      up_data = 6'(i);
      n_cmp++;
      if (up_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, up_ready); end
      tick();
      exp = 6'(i);
      n_cmp++;
      if (down_valid !== 1'b1 || down_data !== exp) begin
        n_err++;
        $display("FAIL stream_out i=%0d got vld=%b data=%h exp vld=1 data=%h", i, down_valid, down_data, exp);
      end
    end
    up_valid = 1'b0;
    tick();
    down_ready = 1'b0;
    n_cmp++;
    if (down_valid !== 1'b0) begin n_err++; $display("FAIL stream_empty got=%b exp=0", down_valid); end
  endtask

  task automatic test_full_pop();
    logic [D_WIDTH-1:0] exp;
    down_ready = 1'b0; up_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      up_data = 6'(8'h10 + k);
      tick();
    end
    up_data = 6'h14; down_ready = 1'b1;
    n_cmp++;
    if (up_ready !== 1'b0) begin n_err++; $display("FAIL fullpop_full got=%b exp=0", up_ready); end
    tick();
    down_ready = 1'b0;
    n_cmp++;
    if (up_ready !== 1'b1 || down_data !== 6'h11) begin
      n_err++;
      $display("FAIL fullpop_after got rdy=%b head=%h exp rdy=1 head=11", up_ready, down_data);
    end
    tick();
    up_valid = 1'b0;
    n_cmp++;
    if (up_ready !== 1'b0) begin n_err++; $display("FAIL fullpop_refull got=%b exp=0", up_ready); end
    down_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      exp = 6'(8'h10 + k);
      n_cmp++;
      if (down_valid !== 1'b1 || down_data !== exp) begin
        n_err++;
        $display("FAIL fullpop_drain k=%0d got vld=%b data=%h exp vld=1 data=%h", k, down_valid, down_data, exp);
      end
      tick();
    end
    down_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    down_ready = 1'b0; up_valid = 1'b1;
    up_data = 6'h07; tick();
    up_data = 6'h08; tick();
    up_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (down_valid !== 1'b0 || up_ready !== 1'b1 || down_data !== 6'h00) begin
      n_err++;
      $display("FAIL midrst_status got vld=%b rdy=%b data=%h exp vld=0 rdy=1 data=00", down_valid, up_ready, down_data);
    end
    up_data = 6'h09; up_valid = 1'b1;
    tick();
    up_valid = 1'b0;
    n_cmp++;
    if (down_valid !== 1'b1 || down_data !== 6'h09) begin
      n_err++;
      $display("FAIL midrst_first got vld=%b data=%h exp vld=1 data=09", down_valid, down_data);
    end
    down_ready = 1'b1;
    tick();
    down_ready = 1'b0;
  endtask

  task automatic test_random();
    int cyc;
    int base;
    base = n_push;
    cyc  = 0;
    while ((n_push - base) < 1000 && cyc < 6000) begin
      up_valid   = 1'($urandom_range(0, 1));
      up_data    = 6'($urandom);
      down_ready = 1'($urandom_range(0, 1));
      n_cmp++;
      if (up_ready !== (q.size() < DEPTH) || down_valid !== (q.size() > 0)) begin
        n_err++;
        $display("FAIL rand_status cyc=%0d got rdy=%b vld=%b occ=%0d", cyc, up_ready, down_valid, q.size());
      end
      if (q.size() > 0) begin
        n_cmp++;
        if (down_data !== q[0]) begin
          n_err++;
          $display("FAIL rand_head cyc=%0d got=%h exp=%h", cyc, down_data, q[0]);
        end
      end
      tick();
      cyc++;
    end
    n_cmp++;
    if ((n_push - base) < 1000) begin
      n_err++;
      $display("FAIL rand_budget got pushes=%0d exp=1000", n_push - base);
    end
    up_valid = 1'b0; down_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH && q.size() > 0; i++) begin
      n_cmp++;
      if (down_valid !== 1'b1 || down_data !== q[0]) begin
        n_err++;
        $display("FAIL rand_drain got vld=%b data=%h exp vld=1 data=%h", down_valid, down_data, q[0]);
      end
      tick();
    end
    n_cmp++;
    if (down_valid !== 1'b0) begin n_err++; $display("FAIL rand_empty got=%b exp=0", down_valid); end
    down_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n_push = 0;
    rst = 1'b0; up_valid = 1'b0; down_ready = 1'b0; up_data = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
